alu_sequencer: RTL and testbench

Micro-program sequencer for the register bank (`REG_BANK`) and 32-bit ALU (`K_ALU_32`) datapath. It holds a small loadable program of 16-bit micro-ops `{sel, rd, rs1, rs2}` and steps through them after a start pulse. For each op it drives the ALU select, the register addresses and the register write enable. It supports a conditional branch on the ALU zero flag, a halt op and a runaway-step limit, and reports completion with a busy/done handshake.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_if.sv | 21 ++
 rtl/seq_prog_mem.sv | 35 +++
 rtl/alu_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the micro-program sequencer: opcodes, micro-op
// field layout, FSM state encoding and the program-memory reset word.
package alu_seq_pkg;

   localparam logic [3:0]  OP_BZ      = 4'b1110;
   localparam logic [3:0]  OP_HALT    = 4'b1111;
   localparam logic [15:0] PROG_RESET = 16'hF000;

   // Bit positions of the micro-op fields inside a 16-bit program word.
   localparam int SEL_MSB = 15;
   localparam int SEL_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;

   typedef struct packed {
      logic [SEL_MSB-SEL_LSB:0] sel;
      logic [RD_MSB-RD_LSB:0]   rd;
      logic [RS1_MSB-RS1_LSB:0] rs1;
      logic [RS2_MSB-RS2_LSB:0] rs2;
   } uop_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_DONE  = 2'd3
   } seq_state_t;

   // Every select below the branch opcode is a plain ALU operation.
   function automatic logic is_alu_op(input logic [3:0] sel);
      return (sel < OP_BZ);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus between the sequencer and the register bank / ALU datapath.
// The sequencer drives the ALU select, register addresses and write
// enable; the datapath returns the zero flag of the current ALU result.
interface alu_seq_if;
   logic [3:0] alu_sel;
   logic [3:0] rd_addr;
   logic [3:0] rs1_addr;
   logic [3:0] rs2_addr;
   logic       reg_we;
   logic       alu_zero;

   modport master (
      output alu_sel, rd_addr, rs1_addr, rs2_addr, reg_we,
      input  alu_zero
   );

   modport slave (
      input  alu_sel, rd_addr, rs1_addr, rs2_addr, reg_we,
      output alu_zero
   );
endinterface

// File: rtl/seq_prog_mem.sv
// 16 x 16 program store. One write port, one registered read port whose
// output register is the sequencer's instruction register.
module seq_prog_mem
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  logic [15:0] wdata,
   input  logic        re,
   input  logic [3:0]  raddr,
   output logic [15:0] rdata
);

   logic [15:0] mem [16];

   // Write port plus registered read; reset fills the store with HALT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            mem[i] <= PROG_RESET;
         end
         rdata <= PROG_RESET;
      end else begin
         if (we) begin
            mem[waddr] <= wdata;
         end
         if (re) begin
            rdata <= mem[raddr];
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Micro-program sequencer driving the register bank and 32-bit ALU.
//
// Handshake: start is a level sampled only in IDLE; when accepted the run
// begins and busy is high from FETCH through EXEC. Completion is a one-cycle
// done pulse, with err telling whether the run hit the step limit. start and
// prog_we are ignored while busy or done is high.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned MAX_STEPS = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [3:0]   start_pc,
   input  logic         prog_we,
   input  logic [3:0]   prog_addr,
   input  logic [15:0]  prog_data,
   alu_seq_if.master    alu,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [3:0]   pc,
   output seq_state_t   dbg_state
);

   localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

   seq_state_t  state;
   logic [15:0] ir_word;
   uop_t        ir;
   logic [7:0]  step_cnt;
   logic [7:0]  step_nxt;
   logic        z_flag;
   logic        err_q;
   logic [3:0]  pc_q;
   logic [3:0]  hold_sel;
   logic [3:0]  hold_rd;
   logic [3:0]  hold_rs1;
   logic [3:0]  hold_rs2;
   logic        exec_alu;

   assign ir       = uop_t'(ir_word);
   assign step_nxt = step_cnt + 8'd1;
   assign exec_alu = (state == S_EXEC) && is_alu_op(ir.sel);

   seq_prog_mem u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    ((state == S_IDLE) && prog_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .re    (state == S_FETCH),
      .raddr (pc_q),
      .rdata (ir_word)
   );

   // Sequencer FSM with pc, step counter, zero flag, error and held fields.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         pc_q     <= 4'd0;
         step_cnt <= 8'd0;
         z_flag   <= 1'b0;
         err_q    <= 1'b0;
         hold_sel <= 4'd0;
         hold_rd  <= 4'd0;
         hold_rs1 <= 4'd0;
         hold_rs2 <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc_q     <= start_pc;
                  step_cnt <= 8'd0;
                  err_q    <= 1'b0;
                  state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_EXEC;
            end
            S_EXEC: begin
               step_cnt <= step_nxt;
               if (ir.sel == OP_HALT) begin
                  state <= S_DONE;
               end else begin
                  if (is_alu_op(ir.sel)) begin
                     z_flag   <= alu.alu_zero;
                     pc_q     <= pc_q + 4'd1;
                     hold_sel <= ir.sel;
                     hold_rd  <= ir.rd;
                     hold_rs1 <= ir.rs1;
                     hold_rs2 <= ir.rs2;
                  end else begin
                     pc_q <= z_flag ? ir.rd : (pc_q + 4'd1);
                  end
                  if (step_nxt == STEP_LIMIT) begin
                     err_q <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode from registers only; fields show the live op during an
   // ALU EXEC and otherwise hold the last ALU op's values.
   always_comb begin
      alu.alu_sel  = exec_alu ? ir.sel : hold_sel;
      alu.rd_addr  = exec_alu ? ir.rd  : hold_rd;
      alu.rs1_addr = exec_alu ? ir.rs1 : hold_rs1;
      alu.rs2_addr = exec_alu ? ir.rs2 : hold_rs2;
      alu.reg_we   = exec_alu;
      busy         = (state == S_FETCH) || (state == S_EXEC);
      done         = (state == S_DONE);
      err          = err_q;
      pc           = pc_q;
      dbg_state    = state;
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed and random programs, each run predicted
// by a program-level interpreter and checked by a scoreboard monitor.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   localparam int MAXS = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  start_pc = 4'd0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = 4'd0;
   logic [15:0] prog_data = 16'd0;
   logic        busy, done, err;
   logic [3:0]  pc;
   seq_state_t  dbg_state;
   logic [15:0] zmask = 16'd0;

   alu_seq_if bus ();

   // Stand-in ALU: zero flag is a per-select lookup chosen by the bench.
   assign bus.alu_zero = zmask[bus.alu_sel];

   alu_sequencer #(.MAX_STEPS(MAXS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .start_pc  (start_pc),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .alu       (bus),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .pc        (pc),
      .dbg_state (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] exp_q[$];
   logic [3:0]  exp_pc_q[$];
   logic [4:0]  exp_run_q[$];
   logic [15:0] ref_mem [16];
   logic        ref_z;
   logic [15:0] prog [16];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Program-level interpreter: walks the program and predicts writes,
   // EXEC pcs, the final {err,pc} and the start-to-done cycle count.
   task automatic model_run(input logic [3:0] spc, output int cyc);
      logic [3:0]  p;
      logic [15:0] w;
      logic        e;
      logic        fin;
      int          steps;
      p = spc; e = 1'b0; fin = 1'b0; steps = 0;
      while (!fin) begin
         w = ref_mem[p];
         steps++;
         exp_pc_q.push_back(p);
         if (w[15:12] == 4'hF) begin
            fin = 1'b1;
         end else begin
            if (w[15:12] < 4'hE) begin
               exp_q.push_back(w);
               ref_z = zmask[w[15:12]];
               p = p + 4'd1;
            end else begin
               p = ref_z ? w[11:8] : p + 4'd1;
            end
            if (steps == MAXS) begin
               e = 1'b1;
               fin = 1'b1;
            end
         end
      end
      exp_run_q.push_back({e, p});
      cyc = 2 * steps + 1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         if (bus.reg_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", {bus.alu_sel, bus.rd_addr, bus.rs1_addr, bus.rs2_addr}, 32'hDEAD);
            end else begin
               check("reg_write", {bus.alu_sel, bus.rd_addr, bus.rs1_addr, bus.rs2_addr}, exp_q.pop_front());
            end
         end
         if (dbg_state == S_EXEC) begin
            if (exp_pc_q.size() == 0) check("unexpected_exec", pc, 32'hDEAD);
            else check("exec_pc", pc, exp_pc_q.pop_front());
         end
         if (done) begin
            if (exp_run_q.size() == 0) check("unexpected_done", {err, pc}, 32'hDEAD);
            else check("done_err_pc", {err, pc}, exp_run_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      start = 1'b0;
      prog_we = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_outs", {busy, done, err, pc, bus.reg_we}, 32'd0);
      check("rst_bus", {bus.alu_sel, bus.rd_addr, bus.rs1_addr, bus.rs2_addr}, 32'd0);
      exp_q.delete();
      exp_pc_q.delete();
      exp_run_q.delete();
      for (int i = 0; i < 16; i++) ref_mem[i] = PROG_RESET;
      ref_z = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_prog();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         prog_we = 1'b1;
         prog_addr = 4'(i);
         prog_data = prog[i];
         ref_mem[i] = prog[i];
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = PROG_RESET;
   endtask

   // Driver: one run, optionally with busy-time noise or a write issued in
   // the same cycle as start.
   task automatic run(input logic [3:0] spc, input bit noise, input bit wr,
                      input logic [3:0] wa, input logic [15:0] wd);
      int exp_cyc;
      int cyc;
      if (wr) ref_mem[wa] = wd;
      model_run(spc, exp_cyc);
      @(negedge clk);
      start = 1'b1;
      start_pc = spc;
      prog_we = wr;
      prog_addr = wa;
      prog_data = wd;
      @(negedge clk);
      if (noise) begin
         start = 1'b1;
         start_pc = spc + 4'd5;
         prog_we = 1'b1;
         prog_addr = 4'd1;
         prog_data = 16'($urandom);
      end else begin
         start = 1'b0;
         prog_we = 1'b0;
      end
      cyc = 1;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cyc >= 3) begin
            start = 1'b0;
            prog_we = 1'b0;
         end
      end
      if (!done) begin
         check("done_timeout", 32'd0, 32'd1);
         do_reset();
      end else begin
         check("done_latency", cyc, exp_cyc);
         @(negedge clk);
         check("done_one_cycle", done, 32'd0);
         check("writes_left", exp_q.size(), 32'd0);
      end
   endtask

   int unused_cyc;

   initial begin
      ref_z = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = PROG_RESET;
      repeat (2) @(negedge clk);
      check("reset_outs", {busy, done, err, pc, bus.reg_we}, 32'd0);
      check("reset_state", dbg_state, S_IDLE);
      rst = 1'b1;
      @(negedge clk);

      // HALT at address 0 after reset
      run(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);

      // Straight-line program
      clear_prog();
      prog[0] = 16'h0123; prog[1] = 16'h1415;
      load_prog();
      zmask = 16'h0000;
      run(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);

      // Branch taken / not taken
      clear_prog();
      prog[0] = 16'h2612; prog[1] = 16'hE300;
      load_prog();
      zmask = 16'h0004;
      run(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);
      zmask = 16'h0000;
      run(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);

      // Step limit, then a clean run clears err
      clear_prog();
      prog[0] = 16'h0123; prog[1] = 16'hE000;
      load_prog();
      zmask = 16'h0001;
      run(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);
      check("err_held", err, 32'd1);
      clear_prog();
      prog[0] = 16'h0123; prog[1] = 16'h1415;
      load_prog();
      run(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);

      // pc wrap 15 -> 0
      clear_prog();
      prog[15] = 16'h3111;
      load_prog();
      run(4'd15, 1'b0, 1'b0, 4'd0, 16'd0);

      // start/prog_we while busy are ignored; rerun proves mem unchanged
      clear_prog();
      prog[0] = 16'h0123; prog[1] = 16'h1415; prog[2] = 16'h2222;
      load_prog();
      run(4'd0, 1'b1, 1'b0, 4'd0, 16'd0);
      run(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);

      // Write and start in the same IDLE cycle
      clear_prog();
      load_prog();
      run(4'd0, 1'b0, 1'b1, 4'd0, 16'h5789);

      // Random programs
      for (int it = 0; it < 24; it++) begin
         for (int i = 0; i < 16; i++) begin
            prog[i] = 16'($urandom);
            if ($urandom_range(0, 4) == 0) prog[i][15:12] = 4'hF;
         end
         load_prog();
         zmask = 16'($urandom);
         run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 4'd0, 16'd0);
      end

      // Reset in the middle of EXEC
      clear_prog();
      prog[0] = 16'h0123; prog[1] = 16'hE000;
      load_prog();
      zmask = 16'h0001;
      model_run(4'd0, unused_cyc);
      @(negedge clk);
      start = 1'b1; start_pc = 4'd0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("mid_in_exec", dbg_state, S_EXEC);
      #2 rst = 1'b0;
      #1 check("mid_rst_outs", {bus.reg_we, busy, done, err, pc}, 32'd0);
      do_reset();
      repeat (3) begin
         @(negedge clk);
         check("post_rst_no_write", bus.reg_we, 32'd0);
      end
      run(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
